// File: rtl/vga_frame_reader.sv
// vga_frame_reader: VGA scan-out of a centred gray image from shared RAM; define VGA_BORDER_EN for a white outline.
// Latency: address issued at the counter position; sync, blank and RGB follow one pixel (2 clk) later, aligned.
// Backpressure: none, free-running; the RAM must return q one clk after rdaddress.
module vga_frame_reader #(
    parameter int IMG_W     = 256,
    parameter int IMG_H     = 256,
    parameter int X0        = 192,
    parameter int Y0        = 112,
    parameter int BUF1_BASE = 65536,
    parameter int H_VIS     = 640,
    parameter int H_SYNC_S  = 656,
    parameter int H_SYNC_E  = 751,
    parameter int H_TOTAL   = 800,
    parameter int V_VIS     = 480,
    parameter int V_SYNC_S  = 490,
    parameter int V_SYNC_E  = 491,
    parameter int V_TOTAL   = 525
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        switch,
    input  logic [31:0] q,
    output logic [16:0] rdaddress,
    output logic        vgaclk,
    output logic        hsync,
    output logic        vsync,
    output logic        sync_b,
    output logic        blank_b,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue
);
    localparam int HBW = $clog2(H_TOTAL);
    localparam int VBW = $clog2(V_TOTAL);

    localparam logic [HBW-1:0] H_LAST  = HBW'(H_TOTAL - 1);
    localparam logic [HBW-1:0] H_VIS_C = HBW'(H_VIS);
    localparam logic [HBW-1:0] H_SS    = HBW'(H_SYNC_S);
    localparam logic [HBW-1:0] H_SE    = HBW'(H_SYNC_E);
    localparam logic [HBW-1:0] X_LO    = HBW'(X0);
    localparam logic [HBW-1:0] X_HI    = HBW'(X0 + IMG_W);
    localparam logic [VBW-1:0] V_LAST  = VBW'(V_TOTAL - 1);
    localparam logic [VBW-1:0] V_VIS_C = VBW'(V_VIS);
    localparam logic [VBW-1:0] V_SS    = VBW'(V_SYNC_S);
    localparam logic [VBW-1:0] V_SE    = VBW'(V_SYNC_E);
    localparam logic [VBW-1:0] Y_LO    = VBW'(Y0);
    localparam logic [VBW-1:0] Y_HI    = VBW'(Y0 + IMG_H);

    logic           r_vgaclk;
    logic           r_sw_meta;
    logic           r_sw_sync;
    logic [HBW-1:0] r_hcnt;
    logic [VBW-1:0] r_vcnt;
    logic [16:0]    r_ptr;
    logic [16:0]    r_rdaddress;
    logic           r_d_hs;
    logic           r_d_vs;
    logic           r_d_vis;
    logic           r_d_win;
    logic           r_d_border;
    logic           r_hsync;
    logic           r_vsync;
    logic           r_blank_b;
    logic [7:0]     r_pix;

    logic w_pe;
    logic w_hwrap;
    logic w_vwrap;
    logic w_frame_start;
    logic w_win;
    logic w_vis;
    logic w_hs_n;
    logic w_vs_n;
    logic w_border;
    logic w_unused_q;

    assign w_pe          = r_vgaclk;
    assign w_hwrap       = (r_hcnt == H_LAST);
    assign w_vwrap       = (r_vcnt == V_LAST);
    assign w_frame_start = (r_hcnt == '0) && (r_vcnt == '0);
    assign w_vis         = (r_hcnt < H_VIS_C) && (r_vcnt < V_VIS_C);
    assign w_win         = (r_hcnt >= X_LO) && (r_hcnt < X_HI) && (r_vcnt >= Y_LO) && (r_vcnt < Y_HI);
    assign w_hs_n        = !((r_hcnt >= H_SS) && (r_hcnt <= H_SE));
    assign w_vs_n        = !((r_vcnt >= V_SS) && (r_vcnt <= V_SE));
    assign w_unused_q    = ^q[31:8];

`ifdef VGA_BORDER_EN
    localparam logic [HBW-1:0] X_RING = HBW'(X0 - 1);
    localparam logic [VBW-1:0] Y_RING = VBW'(Y0 - 1);
    logic w_ring_x;
    logic w_ring_y;
    assign w_ring_x = (r_hcnt >= X_RING) && (r_hcnt <= X_HI);
    assign w_ring_y = (r_vcnt >= Y_RING) && (r_vcnt <= Y_HI);
    assign w_border = w_ring_x && w_ring_y && !w_win;
`else
    assign w_border = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vgaclk  <= 1'b0;
            r_sw_meta <= 1'b0;
            r_sw_sync <= 1'b0;
        end else begin
            r_vgaclk  <= ~r_vgaclk;
            r_sw_meta <= switch;
            r_sw_sync <= r_sw_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_pe) begin
            if (w_hwrap) begin
                r_hcnt <= '0;
                r_vcnt <= w_vwrap ? '0 : r_vcnt + 1'b1;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    // Loading the base only at frame start is what latches the buffer choice for a whole frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr       <= '0;
            r_rdaddress <= '0;
        end else if (w_pe) begin
            if (w_frame_start) begin
                r_ptr <= r_sw_sync ? 17'(BUF1_BASE) : 17'd0;
            end else if (w_win) begin
                r_ptr       <= r_ptr + 1'b1;
                r_rdaddress <= r_ptr;
            end
        end
    end

    // Flags wait one pixel in the d-stage so they leave together with the RAM data for the same position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d_hs     <= 1'b1;
            r_d_vs     <= 1'b1;
            r_d_vis    <= 1'b0;
            r_d_win    <= 1'b0;
            r_d_border <= 1'b0;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_blank_b  <= 1'b0;
            r_pix      <= 8'h00;
        end else if (w_pe) begin
            r_d_hs     <= w_hs_n;
            r_d_vs     <= w_vs_n;
            r_d_vis    <= w_vis;
            r_d_win    <= w_win && w_vis;
            r_d_border <= w_border && w_vis;
            r_hsync    <= r_d_hs;
            r_vsync    <= r_d_vs;
            r_blank_b  <= r_d_vis;
            if (r_d_win) begin
                r_pix <= q[7:0];
            end else if (r_d_border) begin
                r_pix <= 8'hFF;
            end else begin
                r_pix <= 8'h00;
            end
        end
    end

    assign rdaddress = r_rdaddress;
    assign vgaclk    = r_vgaclk;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign sync_b    = 1'b0;
    assign blank_b   = r_blank_b;
    assign red       = r_pix;
    assign green     = r_pix;
    assign blue      = r_pix;
endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: a full-size instance for line timing and a shrunken-geometry instance
// that runs whole frames, both checked every cycle against a position-arithmetic model.
module tb_vga_frame_reader;
    typedef struct packed {
        int ht; int hv; int hss; int hse;
        int vt; int vv; int vss; int vse;
        int iw; int ih; int x0; int y0; int b1;
    } geom_t;

    typedef struct packed {
        logic        vc;
        logic        hs;
        logic        vs;
        logic        bl;
        logic [7:0]  pix;
        logic [16:0] addr;
    } out_t;

    localparam geom_t GD = '{800, 640, 656, 751, 525, 480, 490, 491, 256, 256, 192, 112, 65536};
    localparam geom_t GS = '{40, 32, 34, 36, 30, 24, 26, 27, 16, 8, 8, 6, 130944};

`ifdef VGA_BORDER_EN
    localparam bit         BORDER   = 1'b1;
    localparam logic [7:0] RING_PIX = 8'hFF;
`else
    localparam bit         BORDER   = 1'b0;
    localparam logic [7:0] RING_PIX = 8'h00;
`endif

    logic        clk;
    logic        reset;
    logic        switch;
    logic [31:0] q_d, q_s;
    logic [16:0] rd_d, rd_s;
    logic        vc_d, hs_d, vs_d, sb_d, bl_d;
    logic        vc_s, hs_s, vs_s, sb_s, bl_s;
    logic [7:0]  r_d, g_d, b_d, r_s, g_s, b_s;

    int n_total = 0;
    int n_bad   = 0;
    int kk;
    int run = 0;
    bit bsel [2][64];

    vga_frame_reader u_dflt (
        .clk(clk), .reset(reset), .switch(switch), .q(q_d), .rdaddress(rd_d),
        .vgaclk(vc_d), .hsync(hs_d), .vsync(vs_d), .sync_b(sb_d), .blank_b(bl_d),
        .red(r_d), .green(g_d), .blue(b_d)
    );

    vga_frame_reader #(
        .IMG_W(16), .IMG_H(8), .X0(8), .Y0(6), .BUF1_BASE(130944),
        .H_VIS(32), .H_SYNC_S(34), .H_SYNC_E(36), .H_TOTAL(40),
        .V_VIS(24), .V_SYNC_S(26), .V_SYNC_E(27), .V_TOTAL(30)
    ) u_small (
        .clk(clk), .reset(reset), .switch(switch), .q(q_s), .rdaddress(rd_s),
        .vgaclk(vc_s), .hsync(hs_s), .vsync(vs_s), .sync_b(sb_s), .blank_b(bl_s),
        .red(r_s), .green(g_s), .blue(b_s)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Synchronous-read RAMs: pixel is the low address byte, upper bits are noise the DUT must ignore.
    always @(posedge clk) begin
        q_d <= {24'($urandom), rd_d[7:0]};
        q_s <= {24'($urandom), rd_s[7:0]};
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) kk <= 0;
        else        kk <= kk + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (kk=%0d)", nm, act, exp, kk);
        end
    endtask

    function automatic logic [16:0] base_of(int inst, int f, geom_t gm);
        return bsel[inst][f] ? 17'(gm.b1) : 17'd0;
    endfunction

    // Address of the most recent window pixel at or before position j (counted from reset).
    function automatic logic [16:0] last_addr(int inst, geom_t gm, int j);
        int fr, f, r, h, v, rows, cols, cnt;
        fr   = gm.ht * gm.vt;
        f    = j / fr;
        r    = j % fr;
        h    = r % gm.ht;
        v    = r / gm.ht;
        rows = (v < gm.y0) ? 0 : ((v - gm.y0 >= gm.ih) ? gm.ih : v - gm.y0);
        cols = 0;
        if (v >= gm.y0 && v < gm.y0 + gm.ih) begin
            cols = h - gm.x0 + 1;
            if (cols < 0)     cols = 0;
            if (cols > gm.iw) cols = gm.iw;
        end
        cnt = rows * gm.iw + cols;
        if (cnt > 0) return base_of(inst, f, gm) + 17'(cnt - 1);
        if (f > 0)   return base_of(inst, f - 1, gm) + 17'(gm.iw * gm.ih - 1);
        return 17'd0;
    endfunction

    // k clk edges after release: pixel positions 0..k/2-1 have been scanned, outputs show position k/2-2.
    function automatic out_t model(int inst, geom_t gm, int k);
        out_t o;
        int n, p, h, v;
        bit vis, win, ring;
        logic [16:0] a;
        n      = k / 2;
        o.vc   = (k % 2 == 1);
        o.hs   = 1'b1;
        o.vs   = 1'b1;
        o.bl   = 1'b0;
        o.pix  = 8'h00;
        o.addr = 17'd0;
        if (n >= 2) begin
            p    = n - 2;
            h    = p % gm.ht;
            v    = (p / gm.ht) % gm.vt;
            o.hs = !(h >= gm.hss && h <= gm.hse);
            o.vs = !(v >= gm.vss && v <= gm.vse);
            vis  = (h < gm.hv) && (v < gm.vv);
            win  = (h >= gm.x0) && (h < gm.x0 + gm.iw) && (v >= gm.y0) && (v < gm.y0 + gm.ih);
            ring = (h >= gm.x0 - 1) && (h <= gm.x0 + gm.iw) && (v >= gm.y0 - 1) && (v <= gm.y0 + gm.ih) && !win;
            o.bl = vis;
            if (vis && win) begin
                a     = last_addr(inst, gm, p);
                o.pix = a[7:0];
            end else if (vis && ring && BORDER) begin
                o.pix = 8'hFF;
            end
        end
        if (n >= 1) o.addr = last_addr(inst, gm, n - 1);
        return o;
    endfunction

    // Frame 0 after reset always shows buffer 0: the cleared synchroniser is what gets latched.
    task automatic record_bsel(input int inst, input geom_t gm);
        int n, fr, f;
        n  = kk / 2;
        fr = gm.ht * gm.vt;
        if (n >= 1 && (n - 1) % fr == 0) begin
            f = (n - 1) / fr;
            if (f < 64) bsel[inst][f] = (f == 0) ? 1'b0 : switch;
        end
    endtask

    task automatic cmp_inst(input int inst, input geom_t gm, input logic vc, input logic hs,
                            input logic vs, input logic sb, input logic bl, input logic [7:0] rr,
                            input logic [7:0] gg, input logic [7:0] bb, input logic [16:0] rd);
        out_t e, a;
        e = model(inst, gm, kk);
        a = '{vc, hs, vs, bl, rr, rd};
        n_total++;
        if (a !== e || gg !== rr || bb !== rr || sb !== 1'b0) begin
            n_bad++;
            $display("FAIL model[%0d] kk=%0d got vc=%b hs=%b vs=%b bl=%b rgb=%h/%h/%h sb=%b addr=%0d want vc=%b hs=%b vs=%b bl=%b rgb=%h addr=%0d",
                     inst, kk, vc, hs, vs, bl, rr, gg, bb, sb, rd, e.vc, e.hs, e.vs, e.bl, e.pix, e.addr);
        end
    endtask

    always @(negedge clk) begin
        record_bsel(0, GD);
        record_bsel(1, GS);
        cmp_inst(0, GD, vc_d, hs_d, vs_d, sb_d, bl_d, r_d, g_d, b_d, rd_d);
        cmp_inst(1, GS, vc_s, hs_s, vs_s, sb_s, bl_s, r_s, g_s, b_s, rd_s);
        if (reset) begin
            case (kk)
                498:  begin chk("ring_pixel_7_6", r_s, RING_PIX); chk("first_win_addr", rd_s, 0); end
                500:  begin chk("first_win_red", r_s, 0); chk("second_win_addr", rd_s, 1); end
                502:  chk("second_win_red", r_s, 1);
                528:  chk("row0_end_addr", rd_s, 15);
                578:  chk("row1_start_addr", rd_s, 16);
                1088: chk("buf0_last_addr", rd_s, 127);
                2000: chk("addr_hold_in_blank", rd_s, 127);
                2898: if (run == 0) chk("buf1_first_addr", rd_s, 130944);
                3488: if (run == 0) chk("buf1_last_addr", rd_s, 131071);
                default: ;
            endcase
        end
    end

    function automatic logic sig(int sel);
        case (sel)
            0:       return hs_d;
            1:       return bl_d;
            default: return vs_s;
        endcase
    endfunction

    // Clk cycles spent at lvl in one pulse, and clk cycles from that pulse start to the next.
    task automatic meas(input int sel, input logic lvl, output int len, output int per);
        int t = 0;
        len = -1;
        per = -1;
        while (sig(sel) == lvl && t < 8000) begin @(negedge clk); t++; end
        while (sig(sel) != lvl && t < 8000) begin @(negedge clk); t++; end
        if (t >= 8000) return;
        len = 0;
        while (sig(sel) == lvl && t < 8000) begin len++; @(negedge clk); t++; end
        per = len;
        while (sig(sel) != lvl && t < 8000) begin per++; @(negedge clk); t++; end
        if (t >= 8000) begin len = -1; per = -1; end
    endtask

    task automatic wait_small_pos(input int lo, input int hi);
        int t = 0;
        int pos = -1;
        while (t < 6000) begin
            @(negedge clk);
            t++;
            pos = (kk >= 2) ? (kk / 2 - 1) % 1200 : -1;
            if (pos >= lo && pos <= hi) break;
        end
        chk("wait_small_pos", (pos >= lo && pos <= hi) ? 1 : 0, 1);
    endtask

    initial begin
        int len, per, t;
        reset  = 1'b0;
        switch = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_hsync", hs_d, 1);
        chk("rst_vsync", vs_d, 1);
        chk("rst_blank", bl_d, 0);
        chk("rst_rgb", {r_d, g_d, b_d}, 0);
        chk("rst_rdaddress", rd_s, 0);
        reset = 1'b1;
        #1 chk("vgaclk_at_release", vc_d, 0);
        @(negedge clk);
        chk("vgaclk_1clk_after_release", vc_d, 1);

        t = 0;
        while (kk < 802 && t < 5000) begin @(negedge clk); t++; end
        switch = 1'b1;

        meas(0, 1'b0, len, per);
        chk("hsync_low_clk", len, 192);
        chk("line_period_clk", per, 1600);
        meas(1, 1'b1, len, per);
        chk("blank_high_clk", len, 1280);
        chk("blank_period_clk", per, 1600);
        meas(2, 1'b0, len, per);
        chk("vsync_low_clk", len, 160);
        chk("frame_period_clk", per, 2400);

        for (int i = 0; i < 3; i++) begin
            wait_small_pos(400, 800);
            switch = 1'($urandom_range(0, 1));
            repeat (1300) @(negedge clk);
        end

        wait_small_pos(420, 420);
        #3 reset = 1'b0;
        #1;
        chk("async_rst_dflt", {vc_d, hs_d, vs_d, bl_d, r_d, rd_d}, {1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 17'd0});
        chk("async_rst_small", {vc_s, hs_s, vs_s, bl_s, r_s, rd_s}, {1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 17'd0});
        repeat (4) @(negedge clk);
        run    = 1;
        switch = 1'($urandom_range(0, 1));
        reset  = 1'b1;

        for (int i = 0; i < 4; i++) begin
            wait_small_pos(400, 800);
            switch = 1'($urandom_range(0, 1));
            repeat (1300) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Display back-end that scans a grayscale framebuffer held in the shared image RAM and drives the VGA DAC pins.
- Generates 640x480@60 timing from the 50 MHz system clock.
- Issues read addresses on the RAM read port and centres a 256x256 image in the visible area.
- The board-level switch selects which of two image buffers is shown: original or processed.

Parameters:
- IMG_W, 256, image width in pixels; one pixel per RAM word.
- IMG_H, 256, image height in pixels.
- X0, 192, first visible column of the image window.
- Y0, 112, first visible row of the image window.
- BUF1_BASE, 65536, word address of the second image buffer; the first buffer starts at 0.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- switch  in  1  buffer select, asynchronous board input: 0 = buffer 0, 1 = buffer 1
- q  in  32  RAM read data; pixel = q[7:0], valid one clk after rdaddress
- rdaddress  out  17  RAM read address, registered
- vgaclk  out  1  25 MHz pixel clock (clk/2 toggle)
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- sync_b  out  1  composite sync to DAC, constant 0
- blank_b  out  1  low outside the 640x480 visible area
- red, green, blue  out  8 each  pixel colour; gray value replicated on all three

Behaviour:
- Reset (reset=0, async):
  - vgaclk=0, counters=0, rdaddress=0, RGB=0, blank_b=0, hsync=1, vsync=1, selected buffer=0.
  - Synchroniser flops are cleared.
  - Reset asserted mid-frame aborts the frame immediately; after release, timing restarts at h=0, v=0.
- Pixel enable pe:
  - pe is high on clk cycles where the vgaclk toggle register is 1, i.e. every second clk.
  - vgaclk is the toggle register output.
- Counters (advance only on pe):
  - hcnt runs 0..799 and wraps to 0.
  - vcnt increments on the hcnt wrap, runs 0..524 and wraps to 0.
- Raw timing at counter position (h, v):
  - hsync low for 656<=h<=751.
  - vsync low for 490<=v<=491.
  - Visible area is h<640 and v<480.
  - Image window: X0<=h<X0+IMG_W and Y0<=v<Y0+IMG_H.
- Buffer select:
  - switch passes through a 2-FF synchroniser.
  - The synchronised value is latched only at the pe where h=0, v=0, so a change mid-frame takes effect on the next frame (no tearing).
- Address generation:
  - Running pointer, no multiplier.
  - Loaded with the selected base at frame start (h=0, v=0).
  - Incremented by 1 on each pe where (h, v) is inside the window.
  - rdaddress is registered from the pointer on pe for in-window pixels and holds otherwise.
  - Last pixel of buffer 1 = 131071 (17-bit full scale); the pointer never wraps within a frame.
- Pipeline and latency:
  - RAM data returns one clk after the address, which is before the next pe.
  - All outputs (hsync, vsync, blank_b, RGB) register on the pe following their counter position, giving a uniform 1-pixel (2 clk) lag so sync and data stay aligned.
- Colour:
  - In window: RGB = q[7:0].
  - Visible but outside window: 0.
  - Not visible: 0 and blank_b=0.

Optional Feature:
- Macro VGA_BORDER_EN.
- Defined: the one-pixel ring just outside the image window (h=X0-1 or h=X0+IMG_W, or v=Y0-1 or v=Y0+IMG_H, bounded to the ring) outputs RGB=8'hFF as a white outline.
- Undefined: the ring is black like the rest of the background.
- Address generation and timing are identical in both builds.

Test Plan:
- Reset held 10 clk, then released:
  - During reset: hsync=1, vsync=1, blank_b=0, RGB=0, rdaddress=0.
  - After release: first vgaclk rising edge occurs 1 clk after release.
- Free-run one line:
  - hsync low for exactly 96 pixel periods (192 clk).
  - Line period = 800 pixels = 1600 clk.
  - blank_b high for 640 pixels per line.
- Free-run one frame:
  - vsync low for exactly 2 lines (3200 clk).
  - Frame period = 525 lines = 840000 clk.
- Buffer 0, RAM model returns q = address[7:0]:
  - rdaddress=0 at first window pixel (192,112).
  - Output red=0x00 at that pixel and 0x01 at the next.
  - rdaddress=255 at the end of the row.
  - rdaddress=256 at (192,113).
  - Last pixel address = 65535.
- switch toggled 0->1 at v=200:
  - Current frame keeps buffer 0 addresses.
  - Next frame's first window address is 65536; last is 131071.
- reset pulsed at h=300, v=150:
  - Outputs return to reset values within the same clk, asynchronously.
  - Next frame restarts from rdaddress = base.
  - With VGA_BORDER_EN, pixel (191,112) outputs RGB=0xFF.
